ex_muldiv_seq: RTL

Multi-cycle sequencer for the RV32M multiply/divide instructions in the EX stage. It accepts one operation from the pipeline and iterates a shift-add multiply or restoring divide, one bit per cycle, over an internal adder/subtractor. It stalls the pipeline until the result is ready. It sits beside the single-cycle ALU; the EX result mux selects `result` when `done` is high.

---
 rtl/ex_muldiv_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: multi-cycle RV32M multiply/divide sequencer for the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle, stalling the pipeline until done.
module ex_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             stall
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d, busy_q, busy_d, done_q, done_d;

    logic               is_div, sa, sb, a_neg, b_neg, div_zero, div_ovf;
    logic [WIDTH-1:0]   mag_a, mag_b, hi, lo, fix_q, fix_r;
    logic [WIDTH:0]     add;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] fix_p;

    // a_q/b_q hold raw operands until PREP; b_q then holds the multiplicand/divisor magnitude
    assign is_div   = op_q[2];
    assign sa       = (op_q == 3'b001) | (op_q == 3'b010) | (op_q == 3'b100) | (op_q == 3'b110);
    assign sb       = (op_q == 3'b001) | (op_q == 3'b100) | (op_q == 3'b110);
    assign a_neg    = sa & a_q[WIDTH-1];
    assign b_neg    = sb & b_q[WIDTH-1];
    assign mag_a    = a_neg ? -a_q : a_q;
    assign mag_b    = b_neg ? -b_q : b_q;
    assign div_zero = is_div & (b_q == '0);
    assign div_ovf  = is_div & ~op_q[0] & (a_q == MIN_NEG) & (b_q == '1);

    assign hi    = acc_q[2*WIDTH-1:WIDTH];
    assign lo    = acc_q[WIDTH-1:0];
    assign add   = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    assign diff  = {1'b0, hi, lo[WIDTH-1]} - {2'b00, b_q};
    assign fix_p = neg_q ? -acc_q : acc_q;
    assign fix_q = neg_q ? -lo : lo;
    assign fix_r = neg_q ? -hi : hi;

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign stall  = busy_q | (start & ~done_q & ~flush);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start & ~done_q) begin
                    state_d = PREP;
                    op_d    = funct3;
                    a_d     = a;
                    b_d     = b;
                end
            end
            PREP: begin
                cnt_d   = '0;
                b_d     = mag_b;
                neg_d   = (is_div & op_q[1]) ? a_neg : a_neg ^ b_neg;
                acc_d   = {{WIDTH{1'b0}}, mag_a};
                state_d = RUN;
                // Special divides load {remainder, quotient} directly and bypass sign fix-up
                if (div_zero) begin
                    acc_d   = {a_q, {WIDTH{1'b1}}};
                    neg_d   = 1'b0;
                    state_d = FIX;
                end else if (div_ovf) begin
                    acc_d   = {{WIDTH{1'b0}}, a_q};
                    neg_d   = 1'b0;
                    state_d = FIX;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                acc_d = !is_div ? {add, lo[WIDTH-1:1]} :
                        diff[WIDTH+1] ? {hi[WIDTH-2:0], lo, 1'b0} :
                        {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
                if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
            end
            FIX: begin
                result_d = is_div ? (op_q[1] ? fix_r : fix_q) :
                           (op_q[1:0] == 2'b00) ? fix_p[WIDTH-1:0] : fix_p[2*WIDTH-1:WIDTH];
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end
endmodule
